// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-add multiplier: default operand
// width and the controller state encoding.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 9;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

endpackage

// File: rtl/multiplier_datapath.sv
// Shift-add datapath: M/Q/A/C registers, the step counter, the adder and the
// combined {C,A,Q} right shifter, sequenced by load/step from the controller.
module multiplier_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     abus,
  input  logic [WIDTH-1:0]     bbus,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] a;
  logic             c;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;

  // Add the multiplicand when the current multiplier bit is set, then move
  // carry, accumulator and multiplier right together by one bit.
  always_comb begin
    sum     = {c, a} + {1'b0, (q[0] ? m : WIDTH'(0))};
    shifted = {sum, q} >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m     <= '0;
      q     <= '0;
      a     <= '0;
      c     <= 1'b0;
      count <= '0;
    end else if (load) begin
      m     <= abus;
      q     <= bbus;
      a     <= '0;
      c     <= 1'b0;
      count <= CW'(WIDTH);
    end else if (step) begin
      c     <= shifted[2*WIDTH];
      a     <= shifted[2*WIDTH-1:WIDTH];
      q     <= shifted[WIDTH-1:0];
      count <= count - CW'(1);
    end
  end

  assign product = {a, q};
  assign last    = (count == CW'(1));

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned multiplier: IDLE/BUSY controller around the shift-add
// datapath; one partial-product step per clock, WIDTH steps per product.
module multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Abus,
  input  logic [WIDTH-1:0]     Bbus,
  output logic [2*WIDTH-1:0]   Pbus,
  output logic                 ready
);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       load;
  logic       step;
  logic       last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start is only honoured in IDLE; BUSY runs until the counter reports the final step.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);

  multiplier_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .abus    (Abus),
    .bbus    (Bbus),
    .product (Pbus),
    .last    (last)
  );

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the sequential multiplier: stimulus pushes expected
// products, a negedge monitor pops and compares on each completion.
module tb_multiplier;

  localparam int unsigned W = 9;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   Abus;
  logic [W-1:0]   Bbus;
  logic [2*W-1:0] Pbus;
  logic           ready;

  int vectors;
  int miscompares;

  logic [2*W-1:0] exp_q[$];
  logic           prev_ready;
  int             busy_cnt;

  multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Abus  (Abus),
    .Bbus  (Bbus),
    .Pbus  (Pbus),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a rising ready marks a completed product.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt   = 0;
      prev_ready = ready;
    end else begin
      if (!ready) begin
        busy_cnt++;
      end else if (!prev_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("product", 32'(Pbus), 32'(exp_q.pop_front()));
          chk("busy_cycles", 32'(busy_cnt), 32'(W));
        end
        busy_cnt = 0;
      end
      prev_ready = ready;
    end
  end

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Issue one operation; with noise, scramble operands and poke start mid-operation.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [2*W-1:0] p;
    wait_idle();
    Abus  = a;
    Bbus  = b;
    start = 1'b1;
    p = (2*W)'(a) * (2*W)'(b);
    exp_q.push_back(p);
    @(posedge clk);
    #1 start = 1'b0;
    if (noise) begin
      Abus = W'($urandom);
      Bbus = W'($urandom);
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0]   qv;
    logic [W-1:0]   bv;
    logic [W-1:0]   rv;
    logic [2*W-1:0] dividend;
    bit             seen;

    vectors     = 0;
    miscompares = 0;
    busy_cnt    = 0;
    prev_ready  = 1'b1;
    start       = 1'b0;
    Abus        = '0;
    Bbus        = '0;
    rst         = 1'b0;

    // Reset pulse before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_pbus", 32'(Pbus), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(ready), 32'd1);
    chk("post_reset_pbus", 32'(Pbus), 32'd0);

    // 13 x 11 and hold after completion.
    do_op(W'(13), W'(11), 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_pbus", 32'(Pbus), 32'd143);
    chk("hold_ready", 32'(ready), 32'd1);

    do_op(W'(511), W'(511), 1'b1);
    do_op(W'(0), W'(300), 1'b1);
    do_op(W'(300), W'(0), 1'b0);

    // start held high; operands change mid-operation for the next product.
    wait_idle();
    Abus  = W'(7);
    Bbus  = W'(6);
    start = 1'b1;
    exp_q.push_back((2*W)'(42));
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 Abus = W'(20);
    Bbus = W'(5);
    exp_q.push_back((2*W)'(100));
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("held_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    chk("ready_one_cycle", 32'(ready), 32'd0);
    start = 1'b0;
    wait_idle();

    // Abort 100 x 50 in busy cycle 4, then a clean 3 x 4.
    do_op(W'(100), W'(50), 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_pbus", 32'(Pbus), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    do_op(W'(3), W'(4), 1'b0);

    // Random products with noise on the inputs while busy.
    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom), 1'b1);
    end

    // Division round trip: quotient * divisor + remainder == dividend.
    for (int i = 0; i < 200; i++) begin
      bv = W'($urandom_range(511, 1));
      dividend = (2*W)'($urandom_range(32'(bv) * 512 - 1, 0));
      qv = W'(dividend / (2*W)'(bv));
      rv = W'(dividend % (2*W)'(bv));
      wait_idle();
      Abus  = qv;
      Bbus  = bv;
      start = 1'b1;
      exp_q.push_back(dividend - (2*W)'(rv));
      @(posedge clk);
      #1 start = 1'b0;
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter WIDTH, default 9, operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 Abus  input  WIDTH  multiplicand operand, unsigned; sampled on the accepting edge only.
REQ-006 Bbus  input  WIDTH  multiplier operand, unsigned; sampled on the accepting edge only.
REQ-007 Pbus  output  2*WIDTH  unsigned product Abus*Bbus; valid whenever ready=1 after a completed operation.
REQ-008 ready  output  1  high when idle and able to accept start; low while computing.

Function
REQ-009 Algorithm: sequential unsigned shift-add, one partial-product step per clock, WIDTH steps total.
REQ-010 Registers: M (WIDTH), Q (WIDTH), A (WIDTH), carry C (1), count (ceil(log2(WIDTH+1)) bits).
REQ-011 FSM states: IDLE, BUSY; no other states.
REQ-012 IDLE, start=1 at an edge: M<=Abus, Q<=Bbus, A<=0, C<=0, count<=WIDTH, state<=BUSY.
REQ-013 IDLE, start=0: all registers hold; Pbus keeps the last product.
REQ-014 BUSY, each edge: {C,A}<=A+(Q[0]?M:0); then {C,A,Q} shifted right one bit as a unit; count<=count-1.
REQ-015 BUSY with count=1 at an edge: final step executes and state<=IDLE.
REQ-016 Pbus = {A,Q} combinationally from registers; intermediate values visible during BUSY are unspecified to users.
REQ-017 ready = (state==IDLE), combinational from state register.
REQ-018 Latency: start accepted at edge E0; ready low after E0; ready high and Pbus correct after edge E0+WIDTH (9 cycles busy at default).
REQ-019 start during BUSY is ignored; operands changing during BUSY have no effect.
REQ-020 start held high continuously: new operation accepted on the first edge in IDLE, so ready is high for exactly one cycle between operations.
REQ-021 No overflow possible: 2*WIDTH-bit result holds (2^WIDTH-1)^2.
REQ-022 Operand of zero still takes full WIDTH cycles; no early termination.

Reset
REQ-023 rst=1 forces immediately, independent of clk: state=IDLE, M=Q=A=0, C=0, count=0.
REQ-024 Reset values of outputs: ready=1, Pbus=0.
REQ-025 Reset asserted during BUSY aborts the operation; partial product discarded; first start after rst deassertion behaves as REQ-012.
REQ-026 start sampled high on the same edge that rst is deasserted is accepted only if rst is low at that edge.

Structure
REQ-027 Shared package mult_pkg holds the state enum (IDLE, BUSY) and the WIDTH default constant.
REQ-028 One sub-module, multiplier_datapath: registers M, Q, A, C, count, adder and shifter, driven by load/step controls.
REQ-029 FSM and ready decode live in multiplier top; datapath reports count==1 back to the FSM.

Verification
REQ-030 rst pulse with no clock edges -> ready=1, Pbus=0 immediately.
REQ-031 Abus=13, Bbus=11, start one cycle -> ready low 9 cycles, then Pbus=143, ready=1, held until next start.
REQ-032 Abus=511, Bbus=511 -> Pbus=261121 after 9 busy cycles; Abus=0, Bbus=300 -> Pbus=0 after 9 busy cycles.
REQ-033 start held high with Abus=7, Bbus=6 then changed to Abus=20, Bbus=5 mid-operation -> first result 42, ready high one cycle, second result 100.
REQ-034 Abus=100, Bbus=50 started, rst asserted at busy cycle 4 -> ready=1, Pbus=0 at once; next start with 3x4 -> Pbus=12.
REQ-035 Round-trip: 200 random divider results (Q,R) for divisor B -> multiplier Q*B plus R equals original dividend for every case.
